// File: rtl/aes_stream_engine.sv
// Streaming AES-128 engine: valid/ready block path, latched key/IV, ECB or
// CBC in either direction, result FIFO. Also carries the iterative cipher,
// inverse cipher and key-expansion blocks it sequences.

package aes_pkg;
  typedef logic [10:0][127:0] round_keys_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse in GF(2^8) as a^254 (maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] g;
    g = ginv(b);
    return g ^ rotl8(g, 1) ^ rotl8(g, 2) ^ rotl8(g, 3) ^ rotl8(g, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return ginv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  // State byte i (FIPS order) lives at bits [127-8*i -: 8]; byte r+4c is row r, column c.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic round_keys_t expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon;
    round_keys_t rk;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return rk;
  endfunction
endpackage

// Combinational schedule: all eleven round keys from the latched key.
module key_expansion (
  input  logic [127:0]        key,
  output aes_pkg::round_keys_t round_keys
);
  assign round_keys = aes_pkg::expand_key(key);
endmodule

// Iterative AES-128 encryptor: one round per cycle, done pulses 10 cycles after start.
module aes_cipher (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [127:0]         block_in,
  input  aes_pkg::round_keys_t round_keys,
  output logic [127:0]         block_out,
  output logic                 done
);
  import aes_pkg::*;
  logic [3:0] round;
  logic       running;

  // Round sequencer; the state register doubles as the result.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      block_out <= '0;
      round     <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        block_out <= block_in ^ round_keys[0];
        round     <= 4'd1;
        running   <= 1'b1;
      end else if (running) begin
        if (round == 4'd10) begin
          block_out <= sub_shift(block_out) ^ round_keys[10];
          running   <= 1'b0;
          done      <= 1'b1;
        end else begin
          block_out <= mix_cols(sub_shift(block_out)) ^ round_keys[round];
          round     <= round + 4'd1;
        end
      end
    end
  end
endmodule

// Iterative AES-128 decryptor (inverse cipher), same 10-cycle latency.
module aes_decipher (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [127:0]         block_in,
  input  aes_pkg::round_keys_t round_keys,
  output logic [127:0]         block_out,
  output logic                 done
);
  import aes_pkg::*;
  logic [3:0] round;
  logic       running;

  // Round sequencer walking the key schedule backwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      block_out <= '0;
      round     <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        block_out <= block_in ^ round_keys[10];
        round     <= 4'd9;
        running   <= 1'b1;
      end else if (running) begin
        if (round == 4'd0) begin
          block_out <= inv_shift_sub(block_out) ^ round_keys[0];
          running   <= 1'b0;
          done      <= 1'b1;
        end else begin
          block_out <= inv_mix_cols(inv_shift_sub(block_out) ^ round_keys[round]);
          round     <= round - 4'd1;
        end
      end
    end
  end
endmodule

module aes_stream_engine #(
  parameter int OUT_DEPTH = 4,
  parameter int CBC_EN    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_load,
  output logic                         cfg_ready,
  input  logic [127:0]                 cfg_key,
  input  logic [127:0]                 cfg_iv,
  input  logic                         cfg_cbc,
  input  logic                         cfg_dec,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [127:0]                 in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [127:0]                 out_data,
  output logic                         busy,
  output logic [$clog2(OUT_DEPTH):0]   out_count
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE, START, WAIT, PUSH} state_t;

  state_t                state;
  logic                  alive;
  logic                  start_pulse;
  logic [127:0]          key_r, chain, c_hold, core_in, result_r;
  logic                  cbc_r, dec_r;
  aes_pkg::round_keys_t  round_keys;
  logic [127:0]          enc_out, dec_out;
  logic                  enc_done, dec_done;
  logic [127:0]          fifo_mem [OUT_DEPTH];
  logic [AW-1:0]         wptr, rptr;
  logic [AW:0]           count;
  logic                  cbc_mode, in_fire, push, pop, core_done;
  logic [127:0]          core_result;

  assign cbc_mode    = (CBC_EN != 0) && cbc_r;
  assign cfg_ready   = (state == IDLE) && (count == '0);
  assign in_ready    = alive && (state == IDLE) && (count < FULL_COUNT);
  assign in_fire     = in_valid && in_ready;
  assign push        = (state == PUSH);
  assign pop         = out_valid && out_ready;
  assign out_valid   = (count != '0);
  assign out_data    = out_valid ? fifo_mem[rptr] : '0;
  assign out_count   = count;
  assign core_done   = dec_r ? dec_done : enc_done;
  assign core_result = dec_r ? (cbc_mode ? dec_out ^ chain : dec_out) : enc_out;

  key_expansion u_key_expansion (.key(key_r), .round_keys(round_keys));

  aes_cipher u_cipher (
    .clk(clk), .rst(rst), .start(start_pulse && !dec_r), .block_in(core_in),
    .round_keys(round_keys), .block_out(enc_out), .done(enc_done)
  );

  aes_decipher u_decipher (
    .clk(clk), .rst(rst), .start(start_pulse && dec_r), .block_in(core_in),
    .round_keys(round_keys), .block_out(dec_out), .done(dec_done)
  );

  // Block sequencer plus configuration and chaining registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      alive       <= 1'b0;
      busy        <= 1'b0;
      start_pulse <= 1'b0;
      key_r       <= '0;
      chain       <= '0;
      c_hold      <= '0;
      core_in     <= '0;
      result_r    <= '0;
      cbc_r       <= 1'b0;
      dec_r       <= 1'b0;
    end else begin
      alive       <= 1'b1;
      start_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_load && cfg_ready) begin
            key_r <= cfg_key;
            chain <= cfg_iv;
            cbc_r <= cfg_cbc;
            dec_r <= cfg_dec;
          end
          if (in_fire) begin
            core_in     <= (!dec_r && cbc_mode) ? (in_data ^ chain) : in_data;
            c_hold      <= in_data;
            start_pulse <= 1'b1;
            busy        <= 1'b1;
            state       <= START;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (core_done) begin
            result_r <= core_result;
            state    <= PUSH;
          end
        end
        PUSH: begin
          if (cbc_mode) chain <= dec_r ? c_hold : result_r;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle cancel in the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage write port.
  // NOTE: storage has no reset; out_data is forced to 0 while empty, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= result_r;
  end
endmodule

// File: tb/tb_aes_stream_engine.sv
// Directed bench for aes_stream_engine using FIPS-197 and SP800-38A vectors.
module tb_aes_stream_engine;
  localparam int DEPTH = 4;
  localparam int LAT   = 10;  // cipher/decipher start-to-done latency

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] SP_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SP_IV    = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] sp_pt  [4] = '{128'h6bc1bee22e409f96e93d7e117393172a,
                               128'hae2d8a571e03ac9c9eb76fac45af8e51,
                               128'h30c81c46a35ce411e5fbc1191a0a52ef,
                               128'hf69f2445df4f9b17ad2b417be66c3710};
  logic [127:0] ecb_ct [4] = '{128'h3ad77bb40d7a3660a89ecaf32466ef97,
                               128'hf5d3d58503b9699de785895a96fdbaaf,
                               128'h43b1cd7f598ece23881b00e3ed030688,
                               128'h7b0c785e27e8ad3f8223207104725dd4};
  logic [127:0] cbc_ct [2] = '{128'h7649abac8119b246cee98e9b12e9197d,
                               128'h5086cb9b507219ee95db113a917678b2};

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_load, cfg_ready, cfg_cbc, cfg_dec;
  logic [127:0] cfg_key, cfg_iv;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, out_data;
  logic [2:0]   out_count;

  int checks = 0;
  int errors = 0;

  aes_stream_engine #(.OUT_DEPTH(DEPTH), .CBC_EN(1)) dut (
    .clk(clk), .rst(rst),
    .cfg_load(cfg_load), .cfg_ready(cfg_ready), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .cfg_cbc(cfg_cbc), .cfg_dec(cfg_dec),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_cfg(input logic [127:0] key, input logic [127:0] iv, input logic cbc, input logic dec);
    cfg_key = key; cfg_iv = iv; cfg_cbc = cbc; cfg_dec = dec; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  // Offers a block and returns on the negedge right after the accepting edge.
  task automatic send(input string tag, input logic [127:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin tick(); n++; end
    check({tag, " accept"}, {127'b0, in_ready}, 128'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [127:0] exp);
    int n = 0;
    while (!out_valid && n < 200) begin tick(); n++; end
    check({tag, " valid"}, {127'b0, out_valid}, 128'd1);
    check(tag, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic wait_count(input string tag, input int target);
    int n = 0;
    while (int'(out_count) != target && n < 200) begin tick(); n++; end
    check(tag, {125'b0, out_count}, 128'(target));
  endtask

  initial begin
    int  lat;
    bit  seen_valid;
    rst = 1'b0; cfg_load = 1'b0; cfg_key = '0; cfg_iv = '0; cfg_cbc = 1'b0; cfg_dec = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset values
    tick(); tick();
    check("rst in_ready",  {127'b0, in_ready},  128'd0);
    check("rst cfg_ready", {127'b0, cfg_ready}, 128'd1);
    check("rst out_valid", {127'b0, out_valid}, 128'd0);
    check("rst out_count", {125'b0, out_count}, 128'd0);
    check("rst out_data",  out_data,            128'd0);
    check("rst busy",      {127'b0, busy},      128'd0);
    rst = 1'b1;
    tick();
    check("post-rst in_ready", {127'b0, in_ready}, 128'd1);

    // FIPS-197 ECB encrypt with latency measurement
    do_cfg(FIPS_KEY, '0, 1'b0, 1'b0);
    send("ecb enc", FIPS_PT);
    check("busy after accept", {127'b0, busy}, 128'd1);
    lat = 0;
    while (!out_valid && lat < 200) begin tick(); lat++; end
    check("ecb latency", 128'(lat), 128'(LAT + 3));
    check("ecb busy cleared", {127'b0, busy}, 128'd0);
    recv("ecb enc data", FIPS_CT);

    // ECB decrypt
    do_cfg(FIPS_KEY, '0, 1'b0, 1'b1);
    send("ecb dec", FIPS_CT);
    recv("ecb dec data", FIPS_PT);

    // SP800-38A CBC encrypt, then decrypt
    do_cfg(SP_KEY, SP_IV, 1'b1, 1'b0);
    send("cbc enc 1", sp_pt[0]);
    recv("cbc enc 1 data", cbc_ct[0]);
    send("cbc enc 2", sp_pt[1]);
    recv("cbc enc 2 data", cbc_ct[1]);
    do_cfg(SP_KEY, SP_IV, 1'b1, 1'b1);
    send("cbc dec 1", cbc_ct[0]);
    recv("cbc dec 1 data", sp_pt[0]);
    send("cbc dec 2", cbc_ct[1]);
    recv("cbc dec 2 data", sp_pt[1]);

    // Back-pressure: fill the FIFO, hold an extra block, then drain
    do_cfg(SP_KEY, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) send("bp fill", sp_pt[i]);
    wait_count("bp full count", DEPTH);
    in_valid = 1'b1;
    in_data  = sp_pt[0];
    for (int i = 0; i < 4; i++) begin
      check("bp in_ready held", {127'b0, in_ready}, 128'd0);
      check("bp head stable", out_data, ecb_ct[0]);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp in_ready after pop", {127'b0, in_ready}, 128'd1);
    check("bp count after pop", {125'b0, out_count}, 128'd3);
    tick();
    in_valid = 1'b0;
    check("bp extra accepted", {127'b0, busy}, 128'd1);
    recv("bp drain 1", ecb_ct[1]);
    recv("bp drain 2", ecb_ct[2]);
    recv("bp drain 3", ecb_ct[3]);
    recv("bp drain extra", ecb_ct[0]);

    // Simultaneous push/pop at count 1 across pointer wrap
    send("pp first", sp_pt[0]);
    wait_count("pp count 1", 1);
    for (int i = 1; i <= 2 * DEPTH; i++) begin
      send("pp", sp_pt[i % 4]);
      repeat (LAT + 2) tick();
      check("pp head before", out_data, ecb_ct[(i - 1) % 4]);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("pp count", {125'b0, out_count}, 128'd1);
      check("pp head after", out_data, ecb_ct[i % 4]);
    end
    recv("pp last", ecb_ct[0]);

    // cfg_load while busy is ignored: key, mode and chain keep their values
    do_cfg(SP_KEY, SP_IV, 1'b1, 1'b0);
    send("ign 1", sp_pt[0]);
    tick(); tick();
    check("ign cfg_ready", {127'b0, cfg_ready}, 128'd0);
    do_cfg(FIPS_KEY, FIPS_PT, 1'b0, 1'b1);
    recv("ign 1 data", cbc_ct[0]);
    send("ign 2", sp_pt[1]);
    recv("ign 2 data", cbc_ct[1]);

    // Reset during WAIT aborts the block
    send("abort", sp_pt[2]);
    repeat (4) tick();
    check("abort busy before", {127'b0, busy}, 128'd1);
    rst = 1'b0;
    #1;
    check("abort busy",      {127'b0, busy},      128'd0);
    check("abort out_valid", {127'b0, out_valid}, 128'd0);
    check("abort out_count", {125'b0, out_count}, 128'd0);
    check("abort out_data",  out_data,            128'd0);
    check("abort cfg_ready", {127'b0, cfg_ready}, 128'd1);
    check("abort in_ready",  {127'b0, in_ready},  128'd0);
    tick(); tick();
    rst = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 3 * LAT; i++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort no output", {127'b0, seen_valid}, 128'd0);
    check("abort in_ready back", {127'b0, in_ready}, 128'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_stream_engine.md
# aes_stream_engine

Streaming AES-128 engine with a valid/ready data path, a latched key/IV configuration, and ECB or CBC chaining in either direction. It sits above the existing `aes_cipher`, `aes_decipher` and `key_expansion` blocks, which it instantiates unchanged and sequences through their start/done interface. Results are buffered in a parametrised output FIFO, so a stalled consumer never loses a block. The engine processes one block at a time.

## Interface
Parameters:
- `OUT_DEPTH`, 4: output FIFO depth in 128-bit blocks; power of two, ≥2.
- `CBC_EN`, 1: 0 removes the chaining logic; `cfg_cbc` is then ignored and treated as 0 (ECB only).

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `cfg_load`  in  1  latch `cfg_key`, `cfg_iv`, `cfg_cbc`, `cfg_dec`; accepted only when `cfg_ready`=1.
- `cfg_ready`  out  1  1 in IDLE with the FIFO empty.
- `cfg_key`  in  128  cipher key.
- `cfg_iv`  in  128  initial chaining value (CBC only).
- `cfg_cbc`  in  1  1 = CBC, 0 = ECB.
- `cfg_dec`  in  1  1 = decrypt, 0 = encrypt.
- `in_valid` / `in_ready`  in / out  1  input block handshake.
- `in_data`  in  128  input block (plaintext or ciphertext).
- `out_valid` / `out_ready`  out / in  1  output block handshake.
- `out_data`  out  128  result block, head of the FIFO.
- `busy`  out  1  1 while a block is inside the cipher.
- `out_count`  out  $clog2(OUT_DEPTH)+1  current FIFO occupancy.

## Operation
- Configuration:
  - `cfg_load`&&`cfg_ready` registers the key (feeding `key_expansion`), the mode bits, and the chain register `chain` ← `cfg_iv`.
  - `cfg_load` while `cfg_ready`=0 is ignored. The bench checks that the configuration is unchanged afterwards.
- FSM states: IDLE, START, WAIT, PUSH.
  - IDLE → START on an input handshake.
  - START: drives a 1-cycle start pulse to the selected cipher, then → WAIT.
  - WAIT: holds until that cipher's done = 1, registers the core result, then → PUSH.
  - PUSH: writes one FIFO entry, then → IDLE.
- `in_ready` = (state==IDLE) && (`out_count` < OUT_DEPTH). A free slot is therefore guaranteed before a block is accepted.
- Encrypt:
  - Core input is `in_data` ^ `chain` in CBC, `in_data` in ECB.
  - In PUSH, CBC: `chain` ← result.
- Decrypt:
  - Core input is `in_data`; the engine also keeps a captured copy `c_hold` ← `in_data`.
  - The pushed value is result ^ `chain` in CBC, result in ECB.
  - In PUSH, CBC: `chain` ← `c_hold`.
- `chain` updates only in PUSH; ECB never modifies it.
- FIFO:
  - Circular buffer with wrap-around read and write pointers.
  - A push (PUSH state) and a pop (`out_valid`&&`out_ready`) in the same cycle leave `out_count` unchanged and are both honoured.
  - `out_valid` = (`out_count` ≠ 0). `out_data` is combinationally the head entry and is held stable while `out_valid`&&!`out_ready`.
- Reset values:
  - FSM = IDLE; `busy`=0; `in_ready`=0 during reset, then 1 once released.
  - `cfg_ready`=1; `out_valid`=0; `out_count`=0; `out_data`=0.
  - Key, `chain`, `c_hold`, the mode bits and both FIFO pointers = 0.
- Reset asserted mid-block (any state) aborts the block: the in-flight result is discarded and the FIFO contents are lost. Cipher submodules receive the same `rst`.

## Timing
- Input accept to start pulse: 1 cycle.
- Start pulse to done: the cipher or decipher latency, L cycles.
- Done to FIFO entry visible (`out_valid`=1 if the FIFO was empty): 2 cycles.
- Total latency from accepted input to `out_valid`: L+3 cycles.
- Throughput: one block per L+4 cycles when `out_ready`=1.
- `busy`=1 from the cycle after acceptance through the PUSH cycle.
- With the FIFO full and `out_ready`=0, `in_ready` stays 0. It rises the cycle after the first pop.

## Test plan
- FIPS-197 ECB encrypt: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → out 69c4e0d86a7b0430d8cdb78070b4c55a, latency L+3.
- ECB decrypt with the same key: in 69c4e0d86a7b0430d8cdb78070b4c55a → out 00112233445566778899aabbccddeeff.
- SP800-38A CBC encrypt, key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f:
  - pt 6bc1bee22e409f96e93d7e117393172a → 7649abac8119b246cee98e9b12e9197d.
  - pt ae2d8a571e03ac9c9eb76fac45af8e51 → 5086cb9b507219ee95db113a917678b2.
  - Repeat in decrypt mode and recover both plaintexts.
- Back-pressure: `out_ready`=0, feed OUT_DEPTH+1 blocks.
  - `out_count` reaches OUT_DEPTH and `in_ready` holds 0; `out_data` stays stable.
  - Release `out_ready`: all blocks drain in order, and the extra block is then accepted.
- Simultaneous push/pop with `out_count`=1 → count stays 1, data order preserved across pointer wrap (2×OUT_DEPTH blocks).
- Reset during WAIT:
  - All outputs return to their reset values, and no block appears on `out_valid` after release.
  - `cfg_load` issued while `busy`=1 is ignored.
